// File: rtl/text_iter_arbiter.sv
// Round-robin owner of the text_buffer iterator port: renderer (A, visible
// iteration) and parser (B, full iteration) take turns, one iteration per grant.
module text_iter_arbiter #(
  parameter int unsigned SYMBOL_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req,
  output logic                    a_grant,
  input  logic                    a_en,
  output logic                    a_valid,
  output logic                    a_done,
  input  logic                    b_req,
  output logic                    b_grant,
  input  logic                    b_en,
  output logic                    b_valid,
  output logic                    b_done,
  output logic [SYMBOL_WIDTH-1:0] sym_out,
  output logic                    cursor_left_out,
  output logic                    cursor_right_out,
  output logic                    tb_full_iter_start,
  output logic                    tb_visible_iter_start,
  output logic                    tb_iter_en,
  input  logic [SYMBOL_WIDTH-1:0] tb_iter_out,
  input  logic                    tb_iter_out_valid,
  input  logic                    tb_cursor_left,
  input  logic                    tb_cursor_right
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_RELEASE
  } state_e;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  logic   done_d;
  logic   granted_d;
  logic   a_grant_q, a_grant_d;
  logic   b_grant_q, b_grant_d;
  logic   a_done_q, a_done_d;
  logic   b_done_q, b_done_d;

  logic   own_req;
  logic   own_en;
  logic   port_active;
  logic   sym_nul;

  assign own_req     = (owner_q == OWN_A) ? a_req : b_req;
  assign own_en      = (owner_q == OWN_A) ? a_en  : b_en;
  assign port_active = (state_q == ST_START) || (state_q == ST_STREAM);
  assign sym_nul     = (tb_iter_out == '0);

  // Next state, owner selection and registered output values
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          state_d = ST_START;
          if (a_req && b_req) begin
            owner_d = (last_q == OWN_A) ? OWN_B : OWN_A;
          end else begin
            owner_d = a_req ? OWN_A : OWN_B;
          end
        end
      end
      ST_START: begin
        if (!own_req) begin
          state_d = ST_RELEASE;
        end else if (tb_iter_out_valid) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Completing on the NUL handshake wins over a simultaneous req drop
        if (tb_iter_out_valid && sym_nul && own_en) begin
          state_d = ST_RELEASE;
          done_d  = 1'b1;
        end else if (!own_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    granted_d = (state_d == ST_START) || (state_d == ST_STREAM);
    a_grant_d = granted_d && (owner_d == OWN_A);
    b_grant_d = granted_d && (owner_d == OWN_B);
    a_done_d  = done_d && (owner_q == OWN_A);
    b_done_d  = done_d && (owner_q == OWN_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      last_q    <= OWN_B;
      a_grant_q <= 1'b0;
      b_grant_q <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      a_grant_q <= a_grant_d;
      b_grant_q <= b_grant_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
    end
  end

  assign a_grant = a_grant_q;
  assign b_grant = b_grant_q;
  assign a_done  = a_done_q;
  assign b_done  = b_done_q;

  // Start lines, flow control and symbol stream are zero-latency paths
  assign tb_visible_iter_start = (state_q == ST_START) && (owner_q == OWN_A);
  assign tb_full_iter_start    = (state_q == ST_START) && (owner_q == OWN_B);
  assign tb_iter_en            = port_active && own_en;
  assign a_valid = (state_q == ST_STREAM) && (owner_q == OWN_A) && tb_iter_out_valid;
  assign b_valid = (state_q == ST_STREAM) && (owner_q == OWN_B) && tb_iter_out_valid;

  assign sym_out          = tb_iter_out;
  assign cursor_left_out  = tb_cursor_left;
  assign cursor_right_out = tb_cursor_right;

endmodule

// File: tb/tb_text_iter_arbiter.sv
// Bench for text_iter_arbiter: directed scenarios plus random requesters,
// checked every cycle against a transaction-level model of grants and streams.
module tb_text_iter_arbiter;

  localparam int unsigned SW = 7;
  localparam int NONE = 0;
  localparam int OA   = 1;
  localparam int OB   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_en = 1'b0, b_req = 1'b0, b_en = 1'b0;
  logic          a_grant, a_valid, a_done, b_grant, b_valid, b_done;
  logic [SW-1:0] sym_out;
  logic          cursor_left_out, cursor_right_out;
  logic          tb_full_iter_start, tb_visible_iter_start, tb_iter_en;
  logic [SW-1:0] tb_iter_out;
  logic          tb_iter_out_valid;
  logic          tb_cursor_left = 1'b0, tb_cursor_right = 1'b0;
  logic          stall = 1'b0;

  always #5 clk = ~clk;

  text_iter_arbiter #(.SYMBOL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_grant(a_grant), .a_en(a_en), .a_valid(a_valid), .a_done(a_done),
    .b_req(b_req), .b_grant(b_grant), .b_en(b_en), .b_valid(b_valid), .b_done(b_done),
    .sym_out(sym_out), .cursor_left_out(cursor_left_out), .cursor_right_out(cursor_right_out),
    .tb_full_iter_start(tb_full_iter_start), .tb_visible_iter_start(tb_visible_iter_start),
    .tb_iter_en(tb_iter_en), .tb_iter_out(tb_iter_out), .tb_iter_out_valid(tb_iter_out_valid),
    .tb_cursor_left(tb_cursor_left), .tb_cursor_right(tb_cursor_right)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Text buffer stand-in: start (level) restarts the chosen string, iter_en consumes
  logic [SW-1:0] full_m [16];
  logic [SW-1:0] vis_m  [16];
  logic          tbm_active = 1'b0;
  logic          tbm_vis = 1'b0;
  logic [3:0]    tbm_ptr = 4'd0;

  task automatic set_strs(input string f, input string v);
    for (int i = 0; i < 16; i++) begin
      full_m[i] = (i < f.len()) ? SW'(f[i]) : '0;
      vis_m[i]  = (i < v.len()) ? SW'(v[i]) : '0;
    end
  endtask

  assign tb_iter_out       = tbm_vis ? vis_m[tbm_ptr] : full_m[tbm_ptr];
  assign tb_iter_out_valid = tbm_active && !stall;

  always @(posedge clk) begin
    if (tb_visible_iter_start || tb_full_iter_start) begin
      tbm_active <= 1'b1;
      tbm_ptr    <= 4'd0;
      tbm_vis    <= tb_visible_iter_start;
    end else if (tb_iter_out_valid && tb_iter_en) begin
      if (tb_iter_out == '0) tbm_active <= 1'b0;
      else tbm_ptr <= tbm_ptr + 4'd1;
    end
  end

  // Reference model: who owns the port, whether its stream has started, and
  // which string position the owner should receive next.
  int       m_owner = NONE, m_last = OB, m_free = 2, m_idx = 0;
  bit       m_seen = 1'b0, m_rstprev = 1'b1;
  logic     pv_areq = 1'b0, pv_breq = 1'b0, pv_aen = 1'b0, pv_ben = 1'b0, pv_tbv = 1'b0;
  logic [SW-1:0] pv_sym = '0;
  int       grant_log[$];
  int       a_done_cnt = 0, b_done_cnt = 0, a_rx_cnt = 0, b_rx_cnt = 0;
  bit       oreq, oen, ovalid, exp_ad, exp_bd, exp_av, exp_bv;
  logic [SW-1:0] exp_ch;

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      check("rst_outputs", 32'({a_grant, b_grant, a_done, b_done, a_valid, b_valid,
                                tb_full_iter_start, tb_visible_iter_start, tb_iter_en}), 32'd0);
      m_owner = NONE; m_last = OB; m_free = 2; m_seen = 1'b0; m_rstprev = 1'b1;
    end else begin
      exp_ad = 1'b0;
      exp_bd = 1'b0;
      if (m_rstprev) begin
        m_rstprev = 1'b0;
      end else if (m_owner != NONE) begin
        oreq   = (m_owner == OA) ? pv_areq : pv_breq;
        oen    = (m_owner == OA) ? pv_aen : pv_ben;
        ovalid = m_seen && pv_tbv;
        if (ovalid && pv_sym == '0 && oen) begin
          if (m_owner == OA) exp_ad = 1'b1; else exp_bd = 1'b1;
          m_last = m_owner; m_owner = NONE; m_free = 1;
        end else if (!oreq) begin
          m_last = m_owner; m_owner = NONE; m_free = 1;
        end else if (pv_tbv) begin
          m_seen = 1'b1;
        end
      end else if (m_free >= 2 && (pv_areq || pv_breq)) begin
        if (pv_areq && pv_breq) m_owner = (m_last == OA) ? OB : OA;
        else m_owner = pv_areq ? OA : OB;
        m_seen = 1'b0; m_idx = 0; m_free = 0;
        grant_log.push_back(m_owner);
      end else if (m_free < 2) begin
        m_free++;
      end

      exp_av = (m_owner == OA) && m_seen && tb_iter_out_valid;
      exp_bv = (m_owner == OB) && m_seen && tb_iter_out_valid;
      check("a_grant", 32'(a_grant), 32'(m_owner == OA));
      check("b_grant", 32'(b_grant), 32'(m_owner == OB));
      check("a_done", 32'(a_done), 32'(exp_ad));
      check("b_done", 32'(b_done), 32'(exp_bd));
      check("a_valid", 32'(a_valid), 32'(exp_av));
      check("b_valid", 32'(b_valid), 32'(exp_bv));
      check("vis_start", 32'(tb_visible_iter_start), 32'(m_owner == OA && !m_seen));
      check("full_start", 32'(tb_full_iter_start), 32'(m_owner == OB && !m_seen));
      check("iter_en", 32'(tb_iter_en), 32'((m_owner == OA && a_en) || (m_owner == OB && b_en)));
      check("sym_pass", 32'(sym_out), 32'(tb_iter_out));
      check("cursor_pass", 32'({cursor_left_out, cursor_right_out}),
            32'({tb_cursor_left, tb_cursor_right}));
      if ((exp_av && a_en) || (exp_bv && b_en)) begin
        exp_ch = (m_owner == OA) ? vis_m[m_idx] : full_m[m_idx];
        check(m_owner == OA ? "a_stream_sym" : "b_stream_sym", 32'(sym_out), 32'(exp_ch));
        if (m_idx < 15) m_idx++;
        if (m_owner == OA) a_rx_cnt++; else b_rx_cnt++;
      end
      if (a_done) a_done_cnt++;
      if (b_done) b_done_cnt++;
    end
    pv_areq = a_req; pv_breq = b_req; pv_aen = a_en; pv_ben = b_en;
    pv_tbv = tb_iter_out_valid; pv_sym = tb_iter_out;
  end

  task automatic wait_done(input bit is_a, input int maxc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = is_a ? a_done : b_done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int base, cnt;
  bit hit;

  initial begin
    set_strs("ab", "ab");
    a_req = 1'b1; b_req = 1'b1; a_en = 1'b1; b_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t1_first_grant_a", 32'(a_grant), 32'd1);

    // Both held: alternate A,B,A,B
    for (int i = 0; i < 300 && grant_log.size() < 5; i++) begin
      @(negedge clk);
      #2;
    end
    check("t3_grant_count", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t3_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'(OA) : 32'(OB));
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) @(negedge clk);

    // Lone full iteration for B
    set_strs("abcd", "abcd");
    base = b_done_cnt; cnt = b_rx_cnt;
    b_req = 1'b1;
    wait_done(1'b0, 60, "t2_b_done_timeout");
    @(negedge clk);
    b_req = 1'b0;
    check("t2_b_done_pulses", 32'(b_done_cnt - base), 32'd1);
    check("t2_b_symbols", 32'(b_rx_cnt - cnt), 32'd5);
    repeat (3) @(negedge clk);

    // A backpressures for 3 cycles after 'b'
    cnt = a_rx_cnt;
    a_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #2;
      hit = a_valid && (sym_out == 7'h62);
    end
    check("t4_saw_b", 32'(hit), 32'd1);
    repeat (3) begin
      @(negedge clk);
      a_en = 1'b0;
      #2;
      check("t4_iter_en_low", 32'(tb_iter_en), 32'd0);
    end
    @(negedge clk);
    a_en = 1'b1;
    wait_done(1'b1, 60, "t4_a_done_timeout");
    @(negedge clk);
    a_req = 1'b0;
    check("t4_a_symbols", 32'(a_rx_cnt - cnt), 32'd5);
    repeat (3) @(negedge clk);

    // B aborts after two symbols while A waits
    base = b_done_cnt; cnt = a_rx_cnt;
    a_req = 1'b1; b_req = 1'b1;
    hit = 1'b0;
    for (int i = 0, n = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (b_valid && b_en) n++;
      hit = (n == 2);
    end
    check("t5_b_two_syms", 32'(hit), 32'd1);
    @(negedge clk);
    b_req = 1'b0;
    wait_done(1'b1, 60, "t5_a_done_timeout");
    @(negedge clk);
    a_req = 1'b0;
    check("t5_no_b_done", 32'(b_done_cnt - base), 32'd0);
    check("t5_a_symbols", 32'(a_rx_cnt - cnt), 32'd5);
    repeat (3) @(negedge clk);

    // Reset in the middle of A's stream
    a_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #2;
      hit = a_valid;
    end
    check("t6_streaming", 32'(hit), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("t6_rst_immediate", 32'({a_grant, tb_iter_en, tb_visible_iter_start, tb_full_iter_start}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(1'b1, 60, "t6_a_done_timeout");
    check("t6_regrant_a", 32'(grant_log[grant_log.size()-1]), 32'(OA));
    @(negedge clk);
    a_req = 1'b0;
    repeat (3) @(negedge clk);

    // Random requesters, stalls, cursor flags and occasional reset
    set_strs("x=1+2*3", "x=1");
    repeat (2000) begin
      @(negedge clk);
      if (!a_req) a_req = ($urandom_range(0, 3) == 0);
      else if (a_done) a_req = 1'($urandom_range(0, 1));
      else if (a_grant && $urandom_range(0, 39) == 0) a_req = 1'b0;
      if (!b_req) b_req = ($urandom_range(0, 3) == 0);
      else if (b_done) b_req = 1'($urandom_range(0, 1));
      else if (b_grant && $urandom_range(0, 39) == 0) b_req = 1'b0;
      a_en = ($urandom_range(0, 3) != 0);
      b_en = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      tb_cursor_left = 1'($urandom_range(0, 1));
      tb_cursor_right = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("rand_a_completions", 32'(a_done_cnt > 4), 32'd1);
    check("rand_b_completions", 32'(b_done_cnt > 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
